// File: rtl/instruction_cache.sv
// Direct-mapped, read-only instruction cache. Hits are answered combinationally
// in the same cycle. A miss stalls the CPU, fetches a 16-byte block from
// instruction memory and refills the indexed line.
//
// Memory handshake: while MEM_READ is high, MEM_ADDRESS holds the requested
// block address. The block on MEM_READDATA is accepted on a rising edge where
// MEM_BUSYWAIT is low, except on the first MEM_READ cycle, where MEM_BUSYWAIT
// is ignored. The CPU holds PC while BUSYWAIT is high.
module instruction_cache #(
   parameter int NUM_LINES   = 8,
   parameter int BLOCK_WORDS = 4
) (
   input  logic         CLK,
   input  logic         RESET,
   input  logic [31:0]  PC,
   output logic [31:0]  INSTRUCTION,
   output logic         BUSYWAIT,
   output logic         MEM_READ,
   output logic [5:0]   MEM_ADDRESS,
   input  logic [127:0] MEM_READDATA,
   input  logic         MEM_BUSYWAIT,
   output logic [1:0]   o_dbg_state
);

   localparam int IDX_W = $clog2(NUM_LINES);
   localparam int OFF_W = $clog2(BLOCK_WORDS);
   localparam int TAG_W = 6 - IDX_W;

   typedef enum logic [1:0] {
      S_IDLE     = 2'd0,
      S_MEM_READ = 2'd1,
      S_UPDATE   = 2'd2
   } state_t;

   // Address fields. Only PC[9:0] matters and PC[1:0] is a byte offset.
   logic [TAG_W-1:0] w_tag;
   logic [IDX_W-1:0] w_index;
   logic [OFF_W-1:0] w_offset;
   logic             w_unused_pc;

   assign w_tag       = PC[9:10-TAG_W];
   assign w_index     = PC[4+IDX_W-1:4];
   assign w_offset    = PC[2+OFF_W-1:2];
   assign w_unused_pc = ^{PC[31:10], PC[1:0]};

   // Line storage: valid bits are reset, tag and data contents are not.
   logic [NUM_LINES-1:0] r_valid;
   logic [TAG_W-1:0]     r_tag  [NUM_LINES];
   logic [127:0]         r_data [NUM_LINES];

   // Refill request and FSM state.
   state_t       r_state;
   logic         r_first;
   logic         r_mem_read;
   logic [5:0]   r_req_addr;
   logic [127:0] r_fill;

   logic [IDX_W-1:0] w_req_index;
   logic [TAG_W-1:0] w_req_tag;
   logic             w_hit;
   logic [6:0]       w_bitsel;
   logic [31:0]      w_word;

   assign w_req_index = r_req_addr[IDX_W-1:0];
   assign w_req_tag   = r_req_addr[5:IDX_W];
   assign w_hit       = r_valid[w_index] && (r_tag[w_index] == w_tag);
   assign w_bitsel    = {w_offset, 5'd0};
   assign w_word      = r_data[w_index][w_bitsel +: 32];
   assign o_dbg_state = r_state;

   // Refill FSM: latch the missing block, wait for memory, then commit the line.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         r_state    <= S_IDLE;
         r_first    <= 1'b0;
         r_mem_read <= 1'b0;
         r_req_addr <= 6'd0;
         r_valid    <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (!w_hit) begin
                  r_req_addr <= {w_tag, w_index};
                  r_first    <= 1'b1;
                  r_mem_read <= 1'b1;
                  r_state    <= S_MEM_READ;
               end
            end
            S_MEM_READ: begin
               // The busy flag on the first request cycle still reflects the
               // previous memory transaction, so it is never trusted.
               if (r_first) begin
                  r_first <= 1'b0;
               end else if (!MEM_BUSYWAIT) begin
                  r_fill     <= MEM_READDATA;
                  r_mem_read <= 1'b0;
                  r_state    <= S_UPDATE;
               end
            end
            S_UPDATE: begin
               r_valid[w_req_index] <= 1'b1;
               r_state              <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // Tag and data arrays are written only when a refill completes.
   always_ff @(posedge CLK) begin
      if (!RESET && r_state == S_UPDATE) begin
         r_tag[w_req_index]  <= w_req_tag;
         r_data[w_req_index] <= r_fill;
      end
   end

   // CPU and memory outputs, all forced to zero while reset is held.
   always_comb begin
      INSTRUCTION = 32'd0;
      BUSYWAIT    = 1'b0;
      MEM_READ    = 1'b0;
      MEM_ADDRESS = 6'd0;
      if (!RESET) begin
         INSTRUCTION = w_word;
         BUSYWAIT    = (r_state != S_IDLE) || !w_hit;
         MEM_READ    = r_mem_read;
         MEM_ADDRESS = r_req_addr;
      end
   end

endmodule
